// File: rtl/i2c_slave_regif.sv
// i2c_slave_regif -- I2C responder bridging an external master to a byte-wide
// register space. SCL/SDA are oversampled on clk, synchronised, glitch filtered,
// and the resulting one-clk edge pulses drive a three-process FSM.
//
// Ports:
//   clk        in     system clock, rising edge
//   reset      in     asynchronous, active-low reset
//   i2cAddr    in     7-bit device address, compared when the address byte completes
//   sda        inout  open-drain data, driven 0 or released (z)
//   scl        in     I2C clock (never stretched)
//   memAddr    out    register pointer, auto-increments after each write / read
//   memWrData  out    write data, valid while memWe=1
//   memWe      out    one-clk write strobe
//   memRe      out    one-clk read strobe
//   memRdData  in     read data
//   busy       out    high from an addressed START until STOP or NACK
//   fsm_state  out    current FSM state (debug observation)
//
// Register-side protocol: memWe and memRe are single-cycle strobes that are never
// high together. memWrData/memAddr are valid while memWe=1. After memRe=1 in cycle
// N, memRdData is sampled at the end of cycle N+1, so a registered memory read is fine.
module i2c_slave_regif #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] i2cAddr,
    inout  wire        sda,
    input  logic       scl,
    output logic [7:0] memAddr,
    output logic [7:0] memWrData,
    output logic       memWe,
    output logic       memRe,
    input  logic [7:0] memRdData,
    output logic       busy,
    output logic [3:0] fsm_state
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_DEV_ADDR = 4'd1,
        S_DEV_ACK  = 4'd2,
        S_REG_ADDR = 4'd3,
        S_REG_ACK  = 4'd4,
        S_WR_DATA  = 4'd5,
        S_WR_ACK   = 4'd6,
        S_RD_DATA  = 4'd7,
        S_RD_ACK   = 4'd8
    } state_t;

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    // ---------------- input path: sync -> filter -> registered copy ----------------
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic [1:0]             raw, filt, filt_q;   // index 0 = scl, 1 = sda
    logic [CW-1:0]          fcnt [2];

    assign raw = {sda_sync[SYNC_STAGES-1], scl_sync[SYNC_STAGES-1]};

    // Idle bus is high, so everything resets to 1 to avoid false edges after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
        end
    end

    // A filtered level only changes after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt    <= '1;
            filt_q  <= '1;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == CW'(FILT_LEN - 1)) begin
                    filt[i] <= raw[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + CW'(1);
                end
            end
            filt_q <= filt;
        end
    end

    logic scl_rise, scl_fall, sda_rise, sda_fall, start_cond, stop_cond;
    assign scl_rise   =  filt[0] & ~filt_q[0];
    assign scl_fall   = ~filt[0] &  filt_q[0];
    assign sda_rise   =  filt[1] & ~filt_q[1];
    assign sda_fall   = ~filt[1] &  filt_q[1];
    assign start_cond = sda_fall & filt[0];
    assign stop_cond  = sda_rise & filt[0];

    // ---------------- FSM + datapath ----------------
    state_t     state, state_nxt;
    logic [3:0] bit_cnt;
    logic [7:0] shreg, tx_sh;
    logic       sda_oe, ack_bit, re_d;
    logic       byte_done, addr_hit;

    assign byte_done = (bit_cnt == 4'd8);
    assign addr_hit  = (shreg[7:1] == i2cAddr);
    assign fsm_state = state;
    assign sda       = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start_cond) begin
            state_nxt = S_DEV_ADDR;
        end else if (stop_cond) begin
            state_nxt = S_IDLE;
        end else if (scl_fall) begin
            case (state)
                S_DEV_ADDR: if (byte_done) state_nxt = addr_hit ? S_DEV_ACK : S_IDLE;
                S_DEV_ACK:  state_nxt = shreg[0] ? S_RD_DATA : S_REG_ADDR;
                S_REG_ADDR: if (byte_done) state_nxt = S_REG_ACK;
                S_REG_ACK:  state_nxt = S_WR_DATA;
                S_WR_DATA:  if (byte_done) state_nxt = S_WR_ACK;
                S_WR_ACK:   state_nxt = S_WR_DATA;
                S_RD_DATA:  if (byte_done) state_nxt = S_RD_ACK;
                S_RD_ACK:   state_nxt = ack_bit ? S_IDLE : S_RD_DATA;
                default:    state_nxt = state;
            endcase
        end
    end

    // Action decode: bus conditions win over any bit-level event in the same clk.
    logic cnt_clr, cnt_inc, shift_en, ack_smpl, oe_ack, oe_rel, tx_next, tx_load;
    logic ld_addr, wr_stb, rd_stb, ptr_inc, set_busy, clr_busy;

    always_comb begin
        cnt_clr  = 1'b0; cnt_inc  = 1'b0; shift_en = 1'b0; ack_smpl = 1'b0;
        oe_ack   = 1'b0; oe_rel   = 1'b0; tx_next  = 1'b0; tx_load  = 1'b0;
        ld_addr  = 1'b0; wr_stb   = 1'b0; rd_stb   = 1'b0; ptr_inc  = 1'b0;
        set_busy = 1'b0; clr_busy = 1'b0;
        if (start_cond) begin
            cnt_clr = 1'b1;
            oe_rel  = 1'b1;
        end else if (stop_cond) begin
            oe_rel   = 1'b1;
            clr_busy = 1'b1;
        end else begin
            // Read data arrives one clk after memRe; drive bit 7 straight away.
            if (re_d && state == S_RD_DATA) tx_load = 1'b1;
            if (scl_rise) begin
                case (state)
                    S_DEV_ADDR, S_REG_ADDR, S_WR_DATA: begin
                        shift_en = 1'b1;
                        cnt_inc  = 1'b1;
                    end
                    S_RD_DATA: cnt_inc  = 1'b1;
                    S_RD_ACK:  ack_smpl = 1'b1;
                    default: ;
                endcase
            end
            if (scl_fall) begin
                case (state)
                    S_DEV_ADDR: if (byte_done) begin
                        cnt_clr = 1'b1;
                        if (addr_hit) begin
                            oe_ack   = 1'b1;
                            set_busy = 1'b1;
                        end else begin
                            oe_rel   = 1'b1;
                            clr_busy = 1'b1;
                        end
                    end
                    S_DEV_ACK: begin
                        cnt_clr = 1'b1;
                        oe_rel  = 1'b1;
                        rd_stb  = shreg[0];
                    end
                    S_REG_ADDR: if (byte_done) begin
                        cnt_clr = 1'b1;
                        ld_addr = 1'b1;
                        oe_ack  = 1'b1;
                    end
                    S_REG_ACK, S_WR_ACK: begin
                        cnt_clr = 1'b1;
                        oe_rel  = 1'b1;
                    end
                    S_WR_DATA: if (byte_done) begin
                        cnt_clr = 1'b1;
                        wr_stb  = 1'b1;
                        oe_ack  = 1'b1;
                    end
                    S_RD_DATA: begin
                        if (byte_done) begin
                            cnt_clr = 1'b1;
                            oe_rel  = 1'b1;
                        end else begin
                            tx_next = 1'b1;
                        end
                    end
                    S_RD_ACK: begin
                        cnt_clr = 1'b1;
                        ptr_inc = 1'b1;   // pointer advances on ACK and NACK alike
                        if (ack_bit) clr_busy = 1'b1;
                        else         rd_stb   = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            tx_sh     <= '0;
            sda_oe    <= 1'b0;
            ack_bit   <= 1'b1;
            re_d      <= 1'b0;
            memAddr   <= '0;
            memWrData <= '0;
            memWe     <= 1'b0;
            memRe     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            memWe <= wr_stb;
            memRe <= rd_stb;
            re_d  <= memRe;
            if (cnt_clr)      bit_cnt <= '0;
            else if (cnt_inc) bit_cnt <= bit_cnt + 4'd1;
            if (shift_en) shreg   <= {shreg[6:0], filt[1]};
            if (ack_smpl) ack_bit <= filt[1];
            if (oe_ack) begin
                sda_oe <= 1'b1;
            end else if (oe_rel) begin
                sda_oe <= 1'b0;
            end else if (tx_next) begin
                sda_oe <= ~tx_sh[7];
                tx_sh  <= {tx_sh[6:0], 1'b0};
            end else if (tx_load) begin
                sda_oe <= ~memRdData[7];
                tx_sh  <= {memRdData[6:0], 1'b0};
            end
            if (wr_stb) memWrData <= shreg;
            // Write pointer moves the clk after the memWe pulse; read pointer with memRe.
            if (ld_addr)               memAddr <= shreg;
            else if (ptr_inc || memWe) memAddr <= memAddr + 8'd1;
            if (set_busy)      busy <= 1'b1;
            else if (clr_busy) busy <= 1'b0;
        end
    end

endmodule
